// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - MEM-stage sequencer between the 2-way data cache and the SRAM controller
// Read-allocate, write-through, write-no-allocate; stalls via o_ready while SRAM is busy.
module cache_controller #(
    parameter int unsigned ADDR_BASE = 1024,
    parameter int unsigned CADDR_W   = 19,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_mem_r_en,
    input  logic               i_mem_w_en,
    input  logic [31:0]        i_cpu_addr,
    input  logic [31:0]        i_cpu_wdata,
    output logic [31:0]        o_cpu_rdata,
    output logic               o_ready,
    output logic [CADDR_W-1:0] o_cache_addr,
    output logic [63:0]        o_cache_wdata,
    output logic               o_cache_r_en,
    output logic               o_cache_w_en,
    output logic               o_cache_inv,
    input  logic [31:0]        i_cache_rdata,
    input  logic               i_cache_hit,
    output logic [31:0]        o_sram_addr,
    output logic [31:0]        o_sram_wdata,
    output logic               o_sram_r_en,
    output logic               o_sram_w_en,
    input  logic [63:0]        i_sram_rdata,
    input  logic               i_sram_ready,
    output logic [CNT_W-1:0]   o_hit_cnt,
    output logic [CNT_W-1:0]   o_miss_cnt
);

    localparam logic [31:0] LP_BASE = 32'(ADDR_BASE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_WR_THRU = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [31:0]        w_addr_off;
    logic [31:0]        w_addr_cur;
    logic               w_latch;
    logic               w_hit_inc;
    logic               w_miss_inc;

    assign w_addr_off = i_cpu_addr - LP_BASE;

    // Once a request is accepted, the cache and SRAM see only the latched copy.
    assign w_addr_cur    = (r_state == S_IDLE) ? w_addr_off : r_addr;
    assign o_cache_addr  = w_addr_cur[CADDR_W-1:0];
    assign o_sram_addr   = w_addr_cur;
    assign o_sram_wdata  = r_wdata;
    assign o_cache_wdata = i_sram_rdata;
    assign o_hit_cnt     = r_hit_cnt;
    assign o_miss_cnt    = r_miss_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_addr  <= w_addr_off;
                r_wdata <= i_cpu_wdata;
            end
            if (w_hit_inc && !(&r_hit_cnt)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_miss_inc && !(&r_miss_cnt)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    // Reset gates the outputs too, so a CPU request held across reset cannot stall.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        o_ready      = 1'b1;
        o_cpu_rdata  = '0;
        o_cache_r_en = 1'b0;
        o_cache_w_en = 1'b0;
        o_cache_inv  = 1'b0;
        o_sram_r_en  = 1'b0;
        o_sram_w_en  = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (i_mem_w_en) begin
                        w_latch      = 1'b1;
                        o_cache_inv  = i_cache_hit;
                        o_ready      = 1'b0;
                        w_next_state = S_WR_THRU;
                    end else if (i_mem_r_en) begin
                        if (i_cache_hit) begin
                            o_cache_r_en = 1'b1;
                            o_cpu_rdata  = i_cache_rdata;
                            w_hit_inc    = 1'b1;
                        end else begin
                            w_latch      = 1'b1;
                            w_miss_inc   = 1'b1;
                            o_ready      = 1'b0;
                            w_next_state = S_RD_MISS;
                        end
                    end
                end
                S_RD_MISS: begin
                    o_sram_r_en = 1'b1;
                    o_ready     = i_sram_ready;
                    if (i_sram_ready) begin
                        o_cache_w_en = 1'b1;
                        o_cpu_rdata  = r_addr[2] ? i_sram_rdata[63:32] : i_sram_rdata[31:0];
                        w_next_state = S_IDLE;
                    end
                end
                S_WR_THRU: begin
                    o_sram_w_en = 1'b1;
                    o_ready     = i_sram_ready;
                    if (i_sram_ready) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - scoreboard bench for cache_controller with cache and SRAM models
module tb_cache_controller;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_r_en, mem_w_en;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        ready;
    logic [18:0] cache_addr;
    logic [63:0] cache_wdata;
    logic        cache_r_en, cache_w_en, cache_inv;
    logic [31:0] cache_rdata;
    logic        cache_hit;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_r_en, sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [15:0] hit_cnt, miss_cnt;

    logic        tb_init;
    logic        inj_ready;
    logic        sram_rdy_model;
    int          sram_cnt;

    logic [63:0] sram_mem [64];
    logic        cvalid [64];
    logic [9:0]  ctag [64];
    logic [63:0] cdata [64];
    logic [5:0]  c_idx;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb [$];
    int cnt_cwen = 0, cnt_cinv = 0, cnt_srd = 0, cnt_swr = 0, cnt_cren = 0;
    logic [15:0] exp_hit, exp_miss;

    always #5 clk = ~clk;

    cache_controller dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mem_r_en   (mem_r_en),
        .i_mem_w_en   (mem_w_en),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_rdata  (cpu_rdata),
        .o_ready      (ready),
        .o_cache_addr (cache_addr),
        .o_cache_wdata(cache_wdata),
        .o_cache_r_en (cache_r_en),
        .o_cache_w_en (cache_w_en),
        .o_cache_inv  (cache_inv),
        .i_cache_rdata(cache_rdata),
        .i_cache_hit  (cache_hit),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .o_sram_r_en  (sram_r_en),
        .o_sram_w_en  (sram_w_en),
        .i_sram_rdata (sram_rdata),
        .i_sram_ready (sram_ready),
        .o_hit_cnt    (hit_cnt),
        .o_miss_cnt   (miss_cnt)
    );

    // Cache model (direct-mapped is enough for the addresses used here)
    assign c_idx       = cache_addr[8:3];
    assign cache_hit   = cvalid[c_idx] && (ctag[c_idx] == cache_addr[18:9]);
    assign cache_rdata = cache_addr[2] ? cdata[c_idx][63:32] : cdata[c_idx][31:0];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) cvalid[i] <= 1'b0;
        end else begin
            if (cache_w_en) begin
                cvalid[c_idx] <= 1'b1;
                ctag[c_idx]   <= cache_addr[18:9];
                cdata[c_idx]  <= cache_wdata;
            end
            if (cache_inv) cvalid[c_idx] <= 1'b0;
        end
    end

    // SRAM model: ready pulses after LAT cycles of a held request
    assign sram_rdata = sram_mem[sram_addr[8:3]];
    assign sram_ready = sram_rdy_model | inj_ready;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++)
                sram_mem[i] <= {32'hC0DE_0000 | 32'(2*i+1), 32'hC0DE_0000 | 32'(2*i)};
            sram_mem[0] <= 64'h1111_2222_3333_4444;
        end else if (sram_rdy_model && sram_w_en) begin
            if (sram_addr[2]) sram_mem[sram_addr[8:3]][63:32] <= sram_wdata;
            else              sram_mem[sram_addr[8:3]][31:0]  <= sram_wdata;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_cnt       <= 0;
            sram_rdy_model <= 1'b0;
        end else begin
            sram_rdy_model <= 1'b0;
            if ((sram_r_en || sram_w_en) && !sram_rdy_model) begin
                if (sram_cnt == LAT-1) begin
                    sram_cnt       <= 0;
                    sram_rdy_model <= 1'b1;
                end else begin
                    sram_cnt <= sram_cnt + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (cache_w_en) cnt_cwen <= cnt_cwen + 1;
        if (cache_inv)  cnt_cinv <= cnt_cinv + 1;
        if (cache_r_en) cnt_cren <= cnt_cren + 1;
        if (sram_r_en)  cnt_srd  <= cnt_srd + 1;
        if (sram_w_en)  cnt_swr  <= cnt_swr + 1;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Called at a negedge; returns at a negedge with inputs idle.
    task automatic cpu_op(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rdata);
        logic [31:0] off;
        int          idx;
        bit          phit;
        bit          done;
        off  = addr - 32'd1024;
        idx  = int'(off[8:3]);
        phit = cvalid[idx] && (ctag[idx] == off[18:9]);
        if (!wr && rd) begin
            sb.push_back(off[2] ? sram_mem[idx][63:32] : sram_mem[idx][31:0]);
            if (phit) exp_hit  = sat_inc(exp_hit);
            else      exp_miss = sat_inc(exp_miss);
        end
        mem_r_en  = rd;
        mem_w_en  = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        lat   = 0;
        rdata = '0;
        done  = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            #4;
            if (ready) begin
                done  = 1;
                rdata = cpu_rdata;
                if (!wr && rd) begin
                    if (sb.size() > 0) chk_eq("sb_rdata", cpu_rdata, sb.pop_front());
                    else               chk_eq("sb_empty", 1'b1, 1'b0);
                end
            end else begin
                lat++;
            end
            @(negedge clk);
        end
        if (!done) chk_eq("ready_timeout", 1'b0, 1'b1);
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        chk_eq("hit_cnt", hit_cnt, exp_hit);
        chk_eq("miss_cnt", miss_cnt, exp_miss);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        int          s_cwen, s_cinv, s_srd, s_swr, s_cren;

        rst_n     = 1'b0;
        tb_init   = 1'b1;
        inj_ready = 1'b0;
        mem_r_en  = 1'b0;
        mem_w_en  = 1'b0;
        cpu_addr  = 32'h400;
        cpu_wdata = '0;
        exp_hit   = '0;
        exp_miss  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_eq("rst_ready", ready, 1'b1);
        chk_eq("rst_rdata", cpu_rdata, 32'h0);
        chk_eq("rst_strobes", {cache_r_en, cache_w_en, cache_inv, sram_r_en, sram_w_en}, 5'b0);
        chk_eq("rst_hit", hit_cnt, 16'h0);
        chk_eq("rst_miss", miss_cnt, 16'h0);
        @(negedge clk);
        tb_init = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        // 1: cold load
        s_cwen = cnt_cwen;
        cpu_op(0, 1, 32'h400, 32'h0, lat, rd);
        chk_eq("t1_lat", lat, 6);
        chk_eq("t1_rdata", rd, 32'h3333_4444);
        chk_eq("t1_cwen", cnt_cwen - s_cwen, 1);
        chk_eq("t1_miss", miss_cnt, 16'd1);

        // 2: hit on the other word of the same line
        s_srd = cnt_srd; s_cren = cnt_cren;
        cpu_op(0, 1, 32'h404, 32'h0, lat, rd);
        chk_eq("t2_lat", lat, 0);
        chk_eq("t2_rdata", rd, 32'h1111_2222);
        chk_eq("t2_hit", hit_cnt, 16'd1);
        chk_eq("t2_no_srd", cnt_srd - s_srd, 0);
        chk_eq("t2_cren", cnt_cren - s_cren, 1);

        // 3: store to resident line, then reload misses
        s_cinv = cnt_cinv; s_swr = cnt_swr;
        cpu_op(1, 0, 32'h400, 32'hDEAD_BEEF, lat, rd);
        chk_eq("t3_lat", lat, 6);
        chk_eq("t3_inv", cnt_cinv - s_cinv, 1);
        chk_eq("t3_swr_cycles", cnt_swr - s_swr, LAT + 1);
        cpu_op(0, 1, 32'h400, 32'h0, lat, rd);
        chk_eq("t3_reload_miss", miss_cnt, 16'd2);
        chk_eq("t3_reload_rdata", rd, 32'hDEAD_BEEF);

        // 4: simultaneous read and write takes the write path
        s_srd = cnt_srd; s_swr = cnt_swr; s_cinv = cnt_cinv;
        cpu_op(1, 1, 32'h408, 32'h1234_5678, lat, rd);
        chk_eq("t4_no_srd", cnt_srd - s_srd, 0);
        chk_eq("t4_swr_cycles", cnt_swr - s_swr, LAT + 1);
        chk_eq("t4_no_inv", cnt_cinv - s_cinv, 0);
        cpu_op(0, 1, 32'h408, 32'h0, lat, rd);
        chk_eq("t4_readback", rd, 32'h1234_5678);

        // 5: reset two cycles into an SRAM read wait
        s_cwen    = cnt_cwen;
        mem_r_en  = 1'b1;
        cpu_addr  = 32'h410;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk_eq("t5_pre_srd", sram_r_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_eq("t5_srd_drop", sram_r_en, 1'b0);
        chk_eq("t5_ready", ready, 1'b1);
        chk_eq("t5_hit", hit_cnt, 16'h0);
        chk_eq("t5_miss", miss_cnt, 16'h0);
        exp_hit  = '0;
        exp_miss = '0;
        mem_r_en = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        inj_ready = 1'b1;
        #4;
        chk_eq("t5_late_ready", ready, 1'b1);
        chk_eq("t5_late_cwen", cache_w_en, 1'b0);
        chk_eq("t5_late_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        inj_ready = 1'b0;
        chk_eq("t5_cwen_total", cnt_cwen - s_cwen, 0);
        chk_eq("t5_miss_after", miss_cnt, 16'h0);
        chk_eq("t5_idle_srd", sram_r_en, 1'b0);

        // 6: hit counter saturation
        cpu_op(0, 1, 32'h400, 32'h0, lat, rd);
        mem_r_en = 1'b1;
        cpu_addr = 32'h400;
        for (int i = 0; i < 65536; i++) begin
            exp_hit = sat_inc(exp_hit);
            @(negedge clk);
        end
        mem_r_en = 1'b0;
        chk_eq("t6_sat", hit_cnt, 16'hFFFF);
        chk_eq("t6_sat_model", hit_cnt, exp_hit);
        cpu_op(0, 1, 32'h404, 32'h0, lat, rd);
        chk_eq("t6_hold", hit_cnt, 16'hFFFF);
        chk_eq("t6_rdata", rd, 32'h1111_2222);
        chk_eq("t6_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
